// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the port-side and controller-side access signals seen by the SDRAM port arbiter.
// master drives port requests and controller returns; slave is the arbiter itself.
interface sdram_port_arbiter_if #(
    parameter int NPORTS = 2
);
    logic [NPORTS*32-1:0] port_adr_i;
    logic [NPORTS*16-1:0] port_dat_i;
    logic [NPORTS*2-1:0]  port_sel_i;
    logic [NPORTS-1:0]    port_acc_i;
    logic [NPORTS-1:0]    port_we_i;
    logic [NPORTS-1:0]    port_ack_o;
    logic [31:0]          port_adr_o;
    logic [15:0]          port_dat_o;
    logic [31:0]          ctrl_adr_o;
    logic [15:0]          ctrl_dat_o;
    logic [1:0]           ctrl_sel_o;
    logic                 ctrl_we_o;
    logic                 ctrl_acc_o;
    logic                 ctrl_ack_i;
    logic [31:0]          ctrl_adr_i;
    logic [15:0]          ctrl_dat_i;

    modport master (
        output port_adr_i, port_dat_i, port_sel_i, port_acc_i, port_we_i,
        output ctrl_ack_i, ctrl_adr_i, ctrl_dat_i,
        input  port_ack_o, port_adr_o, port_dat_o,
        input  ctrl_adr_o, ctrl_dat_o, ctrl_sel_o, ctrl_we_o, ctrl_acc_o
    );

    modport slave (
        input  port_adr_i, port_dat_i, port_sel_i, port_acc_i, port_we_i,
        input  ctrl_ack_i, ctrl_adr_i, ctrl_dat_i,
        output port_ack_o, port_adr_o, port_dat_o,
        output ctrl_adr_o, ctrl_dat_o, ctrl_sel_o, ctrl_we_o, ctrl_acc_o
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter multiplexing NPORTS port access interfaces onto one SDRAM controller.
// Grant is held across a whole port transaction, including the short acc gap of a two-burst refill.
module sdram_port_arbiter #(
    parameter int NPORTS        = 2,
    parameter int LINGER_CYCLES = 8
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_rst,
    sdram_port_arbiter_if.slave  bus
);
    localparam int OW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(LINGER_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LINGER = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [OW-1:0]  owner_r;
    logic [OW-1:0]  owner_s;
    logic [OW-1:0]  rr_ptr_r;
    logic [OW-1:0]  rr_ptr_s;
    logic [CW-1:0]  linger_cnt_r;
    logic [CW-1:0]  linger_cnt_s;
    logic [OW-1:0]  pick_s;
    logic [OW-1:0]  next_rr_s;
    logic           own_acc_s;

    logic [NPORTS-1:0] ack_s;
    logic [31:0]       adr_s;
    logic [15:0]       dat_s;
    logic [1:0]        sel_s;
    logic              we_s;
    logic              acc_s;

    function automatic int wrap_idx(input int a);
        return (a >= NPORTS) ? (a - NPORTS) : a;
    endfunction

    // Search downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_s = {OW{1'b0}};
        for (int i = NPORTS - 1; i >= 0; i--) begin
            pick_s = bus.port_acc_i[wrap_idx(int'(rr_ptr_r) + i)] ?
                     OW'(wrap_idx(int'(rr_ptr_r) + i)) : pick_s;
        end
    end

    assign own_acc_s = bus.port_acc_i[owner_r];
    assign next_rr_s = (int'(owner_r) >= NPORTS - 1) ? {OW{1'b0}} : (owner_r + {{(OW-1){1'b0}}, 1'b1});

    // Next-state logic for the grant FSM.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        rr_ptr_s     = rr_ptr_r;
        linger_cnt_s = linger_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|bus.port_acc_i) begin
                    owner_s = pick_s;
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!own_acc_s) begin
                    state_s      = ST_LINGER;
                    linger_cnt_s = CW'(LINGER_CYCLES - 1);
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_LINGER: begin
                if (own_acc_s) begin
                    state_s = ST_GRANT;
                end else if (linger_cnt_r == {CW{1'b0}}) begin
                    state_s  = ST_IDLE;
                    rr_ptr_s = next_rr_s;
                end else begin
                    linger_cnt_s = linger_cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Grant FSM state, owner, round-robin pointer and linger counter.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= {OW{1'b0}};
            rr_ptr_r     <= {OW{1'b0}};
            linger_cnt_r <= {CW{1'b0}};
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            rr_ptr_r     <= rr_ptr_s;
            linger_cnt_r <= linger_cnt_s;
        end
    end

    // Owner request pass-through; ack steered to the owner only. Reset kills acc immediately.
    always_comb begin
        ack_s = {NPORTS{1'b0}};
        adr_s = 32'h0000_0000;
        dat_s = 16'h0000;
        sel_s = 2'b00;
        we_s  = 1'b0;
        acc_s = 1'b0;
        if (state_r != ST_IDLE) begin
            adr_s          = bus.port_adr_i[int'(owner_r)*32 +: 32];
            dat_s          = bus.port_dat_i[int'(owner_r)*16 +: 16];
            sel_s          = bus.port_sel_i[int'(owner_r)*2 +: 2];
            we_s           = bus.port_we_i[owner_r];
            acc_s          = own_acc_s & ~sdram_rst;
            ack_s[owner_r] = bus.ctrl_ack_i;
        end else begin
            acc_s = 1'b0;
        end
    end

    assign bus.port_ack_o = ack_s;
    assign bus.ctrl_adr_o = adr_s;
    assign bus.ctrl_dat_o = dat_s;
    assign bus.ctrl_sel_o = sel_s;
    assign bus.ctrl_we_o  = we_s;
    assign bus.ctrl_acc_o = acc_s;
    assign bus.port_adr_o = bus.ctrl_adr_i;
    assign bus.port_dat_o = bus.ctrl_dat_i;

endmodule
